// File: rtl/param_multiop_shift_register.sv
// Multi-operation WIDTH-bit shift register: hold/load/clear complete in one cycle,
// shifts and rotates step one bit per clock under a start/busy/done handshake.
module param_multiop_shift_register #(
   parameter int WIDTH = 10,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       sel,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] din,
   input  logic             ser_in,
   output logic [WIDTH-1:0] dout,
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_LSL  = 3'b010;
   localparam logic [2:0] OP_LSR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;
   localparam logic [2:0] OP_ROR  = 3'b101;
   localparam logic [2:0] OP_ASR  = 3'b110;
   localparam logic [2:0] OP_CLR  = 3'b111;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_dout;
   logic [WIDTH-1:0] w_dout_next;
   logic [AMT_W-1:0] r_rem;
   logic [AMT_W-1:0] w_rem_next;
   logic [2:0]       r_op;
   logic [2:0]       w_op_next;
   logic             r_done;
   logic             w_done_next;

   logic             w_left_fill;
   logic             w_right_fill;
   logic [WIDTH-1:0] w_left_step;
   logic [WIDTH-1:0] w_right_step;
   logic [WIDTH-1:0] w_step;
   logic             w_single;

   // Bit entering the vacated end depends on the latched operation.
   always_comb begin
      w_left_fill  = ser_in;
      w_right_fill = ser_in;
      case (r_op)
         OP_ROL:  w_left_fill  = r_dout[WIDTH-1];
         OP_ROR:  w_right_fill = r_dout[0];
         OP_ASR:  w_right_fill = r_dout[WIDTH-1];
         default: begin
            w_left_fill  = ser_in;
            w_right_fill = ser_in;
         end
      endcase
   end

   assign w_left_step  = {r_dout[WIDTH-2:0], w_left_fill};
   assign w_right_step = {w_right_fill, r_dout[WIDTH-1:1]};
   assign w_step       = (r_op == OP_LSL || r_op == OP_ROL) ? w_left_step : w_right_step;

   // Zero-amount shifts behave like hold and finish in the accept cycle.
   assign w_single = (sel == OP_HOLD) || (sel == OP_LOAD) || (sel == OP_CLR) ||
                     (amt == '0);

   always_comb begin
      w_state_next = r_state;
      w_dout_next  = r_dout;
      w_rem_next   = r_rem;
      w_op_next    = r_op;
      w_done_next  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_single) begin
                  w_done_next = 1'b1;
                  if (sel == OP_LOAD) begin
                     w_dout_next = din;
                  end else if (sel == OP_CLR) begin
                     w_dout_next = '0;
                  end
               end else begin
                  w_op_next    = sel;
                  w_rem_next   = amt;
                  w_state_next = S_RUN;
               end
            end
         end
         S_RUN: begin
            w_dout_next = w_step;
            w_rem_next  = r_rem - 1'b1;
            if (r_rem <= 1) begin
               w_rem_next   = '0;
               w_state_next = S_IDLE;
               w_done_next  = 1'b1;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_dout  <= '0;
         r_rem   <= '0;
         r_op    <= OP_HOLD;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_dout  <= w_dout_next;
         r_rem   <= w_rem_next;
         r_op    <= w_op_next;
         r_done  <= w_done_next;
      end
   end

   assign dout = r_dout;
   assign busy = (r_state == S_RUN);
   assign done = r_done;

endmodule

// File: tb/tb_param_multiop_shift_register.sv
// Directed test of param_multiop_shift_register with hand-computed results (WIDTH=10).
module tb_param_multiop_shift_register;

   localparam int WIDTH = 10;
   localparam int AMT_W = 4;

   logic             clk;
   logic             rst;
   logic             start;
   logic [2:0]       sel;
   logic [AMT_W-1:0] amt;
   logic [WIDTH-1:0] din;
   logic             ser_in;
   logic [WIDTH-1:0] dout;
   logic             busy;
   logic             done;

   int n_checks = 0;
   int n_errors = 0;

   param_multiop_shift_register #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .sel    (sel),
      .amt    (amt),
      .din    (din),
      .ser_in (ser_in),
      .dout   (dout),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // Counts busy cycles until busy drops; leaves us on the negedge where done should be high.
   task automatic wait_idle(output int cnt);
      int guard;
      cnt   = 0;
      guard = 0;
      while (busy === 1'b1 && guard < 200) begin
         cnt++;
         guard++;
         @(negedge clk);
      end
   endtask

   // Issues one request, waits for completion and checks result, busy length and done pulse.
   task automatic run_op(input string tag, input logic [2:0] s, input int a,
                         input logic [WIDTH-1:0] d, input logic si,
                         input logic [WIDTH-1:0] exp, input int exp_busy);
      int cnt;
      @(negedge clk);
      start  = 1'b1;
      sel    = s;
      amt    = AMT_W'(a);
      din    = d;
      ser_in = si;
      @(negedge clk);
      start = 1'b0;
      wait_idle(cnt);
      check({tag, ".busy_cycles"}, cnt, exp_busy);
      check({tag, ".dout"}, dout, exp);
      check({tag, ".done"}, done, 1'b1);
      @(negedge clk);
      check({tag, ".done_clear"}, done, 1'b0);
   endtask

   initial begin
      int cnt;
      rst    = 1'b1;
      start  = 1'b0;
      sel    = 3'b000;
      amt    = '0;
      din    = '0;
      ser_in = 1'b0;
      @(negedge clk);
      check("reset.dout", dout, 0);
      check("reset.busy", busy, 0);
      check("reset.done", done, 0);
      rst = 1'b0;

      run_op("load_2a5", 3'b001, 0, 10'h2A5, 1'b0, 10'h2A5, 0);
      run_op("rol3", 3'b100, 3, 10'h000, 1'b0, 10'h12D, 3);
      run_op("load_2a5b", 3'b001, 0, 10'h2A5, 1'b0, 10'h2A5, 0);
      run_op("asr2", 3'b110, 2, 10'h000, 1'b1, 10'h3A9, 2);
      run_op("lsr4", 3'b011, 4, 10'h000, 1'b0, 10'h03A, 4);
      run_op("load_2a5c", 3'b001, 0, 10'h2A5, 1'b0, 10'h2A5, 0);
      run_op("lsl4_fill1", 3'b010, 4, 10'h000, 1'b1, 10'h25F, 4);
      run_op("load_2a5d", 3'b001, 0, 10'h2A5, 1'b0, 10'h2A5, 0);
      run_op("ror12", 3'b101, 12, 10'h000, 1'b0, 10'h1A9, 12);
      run_op("ror0", 3'b101, 0, 10'h3FF, 1'b1, 10'h1A9, 0);
      run_op("hold", 3'b000, 5, 10'h3FF, 1'b1, 10'h1A9, 0);
      run_op("clear", 3'b111, 3, 10'h3FF, 1'b0, 10'h000, 0);
      run_op("lsl15_sat", 3'b010, 15, 10'h000, 1'b1, 10'h3FF, 15);

      // Clear request while busy must be ignored.
      run_op("load_2a5e", 3'b001, 0, 10'h2A5, 1'b0, 10'h2A5, 0);
      @(negedge clk);
      start = 1'b1; sel = 3'b100; amt = 4'd3;
      @(negedge clk);
      check("collide.busy", busy, 1'b1);
      sel = 3'b111; amt = 4'd0;
      @(negedge clk);
      start = 1'b0;
      wait_idle(cnt);
      check("collide.busy_cycles", cnt + 1, 3);
      check("collide.dout", dout, 10'h12D);
      check("collide.done", done, 1'b1);

      // Back-to-back: new request accepted on the done cycle.
      @(negedge clk);
      check("collide.done_clear", done, 1'b0);
      start = 1'b1; sel = 3'b101; amt = 4'd2;
      @(negedge clk);
      start = 1'b0;
      wait_idle(cnt);
      check("b2b.ror2.dout", dout, 10'h14B);
      check("b2b.ror2.done", done, 1'b1);
      start = 1'b1; sel = 3'b001; din = 10'h155;
      @(negedge clk);
      start = 1'b0;
      check("b2b.load.dout", dout, 10'h155);
      check("b2b.load.done", done, 1'b1);

      // Asynchronous reset in the middle of a 5-step shift.
      @(negedge clk);
      start = 1'b1; sel = 3'b010; amt = 4'd5; ser_in = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("abort.busy_before", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("abort.dout", dout, 0);
      check("abort.busy", busy, 0);
      check("abort.done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("abort.no_done", done, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/param_multiop_shift_register.md
# param_multiop_shift_register

Parametrised multi-operational shift register: a single WIDTH-bit register supporting hold, parallel load, clear, logical shift left/right, rotate left/right and arithmetic shift right. Shifts and rotates run through a counted, one-bit-per-cycle engine with a start/busy/done handshake. It replaces fixed-width shift registers built from chained 5-bit sub-registers. It sits between datapath sources (parallel and serial) and downstream consumers of `dout`.

## Interface
Parameters:
- `WIDTH`, 10, register width in bits (≥2).
- `AMT_W`, 4, width of the shift-amount input.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request an operation; sampled only when `busy`=0.
- `sel`  in  3  operation code, latched on accept:
  - 000 hold
  - 001 parallel load
  - 010 logical shift left
  - 011 logical shift right
  - 100 rotate left
  - 101 rotate right
  - 110 arithmetic shift right
  - 111 clear
- `amt`  in  AMT_W  number of single-bit steps; latched on accept.
- `din`  in  WIDTH  parallel load data.
- `ser_in`  in  1  fill bit for logical shifts; sampled live on every step.
- `dout`  out  WIDTH  register contents.
- `busy`  out  1  high while a multi-step operation is in progress.
- `done`  out  1  one-cycle pulse when an operation completes.

## Operation
- Two states: IDLE and RUN. A step counter `rem` is AMT_W bits wide.
- **Accept.** On an edge with `start`=1 and state IDLE:
  - If `sel` ∈ {000, 001, 111}, or `amt`=0:
    - Apply the operation at that edge: hold leaves `dout` unchanged, load sets `dout`=`din`, clear sets `dout`=0.
    - Shift/rotate codes with `amt`=0 leave `dout` unchanged.
    - Stay in IDLE. `done`=1 for the next cycle.
  - Otherwise:
    - Latch `sel`, set `rem`=`amt`, go to RUN. `dout` is unchanged at this edge.
- **RUN.** Each edge performs one step and decrements `rem`:
  - Shift left: `dout` = {`dout`[W-2:0], `ser_in`}.
  - Shift right: `dout` = {`ser_in`, `dout`[W-1:1]}.
  - Rotate left: `dout` = {`dout`[W-2:0], `dout`[W-1]}.
  - Rotate right: `dout` = {`dout`[0], `dout`[W-1:1]}.
  - Arithmetic shift right: `dout` = {`dout`[W-1], `dout`[W-1:1]}.
  - On the step where `rem` goes 1→0, return to IDLE and pulse `done` for the next cycle.
- **Amount range.** `amt` may exceed WIDTH; there is no clamping.
  - Logical and arithmetic shifts saturate to all-fill or all-sign.
  - Rotates by k equal rotates by k mod WIDTH.
- `start`, `sel` and `amt` are ignored while `busy`=1. A new request may be accepted on the same edge that `done` is high.
- `din` is used only on a load accept. `ser_in` is used only during logical-shift steps.

## Timing
- **Reset values:** `dout`=0, `busy`=0, `done`=0, state IDLE, `rem`=0.
- **Reset mid-operation:** takes effect immediately and aborts the operation. No `done` is produced.
- **Single-cycle ops:** result is visible after the accept edge, and `done` is high in the same cycle.
- **Shift/rotate, amt=k≥1:**
  - `busy`=1 for exactly k cycles, starting after the accept edge.
  - The final result and `done`=1 are visible after edge k+1 counted from accept; at that point `busy`=0.
- `busy` and `done` are never high in the same cycle.
- `done` is a single-cycle pulse, never held.
- `dout` is registered; there is no combinational path from any input to `dout`.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `dout`=0, `busy`=0, `done`=0 without waiting for a clock edge.
- **Load + rotate left:** load `din`=10'h2A5 → `dout`=2A5 and `done` pulses one cycle later. Then `sel`=100, `amt`=3 → `busy` high 3 cycles, then `dout`=10'h12D with one `done` pulse.
- **Arithmetic shift right:** from 2A5, `sel`=110, `amt`=2 → `dout`=10'h3A9. Then `sel`=011, `amt`=4, `ser_in`=0 → 10'h03A.
- **Logical shift left with fill:** from 2A5, `sel`=010, `amt`=4, `ser_in`=1 → `dout`=10'h25F.
- **Over-range rotate:** from 2A5, `sel`=101, `amt`=12 → `dout`=10'h1A9 after 12 busy cycles. Also `amt`=0 → `dout` unchanged and `done` after 1 cycle.
- **Collisions and abort:**
  - `start` with `sel`=111 while busy → ignored; the operation in progress completes correctly.
  - Back-to-back `start` on the `done` cycle → accepted.
  - `rst` pulse during a 5-step shift → `dout`=0, `busy`=0, and no `done` pulse.
